// File: rtl/z_core_axil_pkg.sv
// Shared definitions for the AXI-Lite SRAM slave: response codes,
// channel FSM encodings and the bus word size.
package z_core_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    W_COLLECT = 2'd0,
    W_COMMIT  = 2'd1,
    W_RESP    = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_t;

endpackage

// File: rtl/z_core_ram_bank.sv
// MEM_WORDS x DATA_WIDTH storage split into byte lanes. One write port with
// per-byte enables, one registered read port. A read and a write to the same
// word on the same edge return the old contents (read-first).
module z_core_ram_bank
  import z_core_axil_pkg::*;
#(
  parameter int MEM_WORDS  = 1024,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          wr_en,
  input  logic [$clog2(MEM_WORDS)-1:0]  wr_idx,
  input  logic [DATA_WIDTH/8-1:0]       wr_be,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          rd_en,
  input  logic [$clog2(MEM_WORDS)-1:0]  rd_idx,
  output logic [DATA_WIDTH-1:0]         rd_data
);

  localparam int LANES = DATA_WIDTH / 8;

  for (genvar b = 0; b < LANES; b++) begin : g_lane
    logic [7:0] lane [MEM_WORDS];
    logic [7:0] q;

    // One byte lane: write when this lane's strobe is set, read-first sample
    always_ff @(posedge clk) begin
      if (wr_en && wr_be[b]) begin
        lane[wr_idx] <= wr_data[8*b +: 8];
      end
      if (rd_en) begin
        q <= lane[rd_idx];
      end
    end

    assign rd_data[8*b +: 8] = q;
  end

endmodule

// File: rtl/z_core_axil_ram.sv
// AXI-Lite slave SRAM. Independent write and read channels, one transaction
// outstanding per channel, byte strobes, address-window decode with SLVERR
// outside the window, and RD_WAIT programmable read wait states.
module z_core_axil_ram
  import z_core_axil_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
  parameter int                    MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000,
  parameter int                    RD_WAIT    = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready
);

  localparam int                    IDX_W     = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] WIN_BYTES = ADDR_WIDTH'(WORD_BYTES * MEM_WORDS);

  // An address below BASE_ADDR wraps to an offset of at least WIN_BYTES
  // because the window lies inside the address space, so one unsigned
  // compare of the offset decodes both window edges.
  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] off);
    return off < WIN_BYTES;
  endfunction

  wr_state_t wr_state, wr_state_nx;
  rd_state_t rd_state, rd_state_nx;

  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic                  aw_hs, w_hs, wr_commit;

  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [3:0]            rd_cnt;
  logic                  ar_hs, rd_sample;

  logic [ADDR_WIDTH-1:0] wr_off, rd_off;
  logic                  wr_hit, rd_hit;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] bank_q;

  assign wr_off = aw_addr - BASE_ADDR;
  assign rd_off = ar_addr - BASE_ADDR;
  assign wr_hit = in_window(wr_off);
  assign rd_hit = in_window(rd_off);
  assign wr_idx = wr_off[IDX_W+1:2];
  assign rd_idx = rd_off[IDX_W+1:2];

  // Protection bits and sub-word address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{s_axil_awprot, s_axil_arprot,
                       wr_off[1:0], wr_off[ADDR_WIDTH-1:IDX_W+2],
                       rd_off[1:0], rd_off[ADDR_WIDTH-1:IDX_W+2]};

  assign aw_hs = s_axil_awvalid & s_axil_awready;
  assign w_hs  = s_axil_wvalid  & s_axil_wready;
  assign ar_hs = s_axil_arvalid & s_axil_arready;

  // ---------------------------------------------------------------- write

  // Write FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_state <= W_COLLECT;
    end else begin
      wr_state <= wr_state_nx;
    end
  end

  // Write FSM next state and channel readies
  always_comb begin
    wr_state_nx    = wr_state;
    s_axil_awready = 1'b0;
    s_axil_wready  = 1'b0;
    wr_commit      = 1'b0;
    case (wr_state)
      W_COLLECT: begin
        s_axil_awready = ~aw_held;
        s_axil_wready  = ~w_held;
        if (aw_held && w_held) begin
          wr_state_nx = W_COMMIT;
        end
      end
      W_COMMIT: begin
        wr_commit   = 1'b1;
        wr_state_nx = W_RESP;
      end
      W_RESP: begin
        if (s_axil_bvalid && s_axil_bready) begin
          wr_state_nx = W_COLLECT;
        end
      end
      default: wr_state_nx = W_COLLECT;
    endcase
  end

  // Held flags and the B channel response
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      s_axil_bvalid <= 1'b0;
      s_axil_bresp  <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
      end
      if (w_hs) begin
        w_held <= 1'b1;
      end
      if (wr_commit) begin
        aw_held       <= 1'b0;
        w_held        <= 1'b0;
        s_axil_bvalid <= 1'b1;
        s_axil_bresp  <= wr_hit ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axil_bvalid && s_axil_bready) begin
        s_axil_bvalid <= 1'b0;
      end
    end
  end

  // Capture the write address and payload as each channel handshakes
  always_ff @(posedge clk) begin
    if (aw_hs) begin
      aw_addr <= s_axil_awaddr;
    end
    if (w_hs) begin
      w_data <= s_axil_wdata;
      w_strb <= s_axil_wstrb;
    end
  end

  // ----------------------------------------------------------------- read

  // Read FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_state <= R_IDLE;
    end else begin
      rd_state <= rd_state_nx;
    end
  end

  // Read FSM next state, arready and the sample strobe
  always_comb begin
    rd_state_nx    = rd_state;
    s_axil_arready = 1'b0;
    rd_sample      = 1'b0;
    case (rd_state)
      R_IDLE: begin
        s_axil_arready = 1'b1;
        if (s_axil_arvalid) begin
          rd_state_nx = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rd_cnt == 4'd0) begin
          rd_sample   = 1'b1;
          rd_state_nx = R_RESP;
        end
      end
      R_RESP: begin
        if (s_axil_rvalid && s_axil_rready) begin
          rd_state_nx = R_IDLE;
        end
      end
      default: rd_state_nx = R_IDLE;
    endcase
  end

  // Wait-state counter and the R channel valid/response
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_cnt        <= 4'd0;
      s_axil_rvalid <= 1'b0;
      s_axil_rresp  <= RESP_OKAY;
    end else begin
      if (ar_hs) begin
        rd_cnt <= 4'(RD_WAIT);
      end else if (rd_state == R_WAIT && rd_cnt != 4'd0) begin
        rd_cnt <= rd_cnt - 4'd1;
      end
      if (rd_sample) begin
        s_axil_rvalid <= 1'b1;
        s_axil_rresp  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axil_rvalid && s_axil_rready) begin
        s_axil_rvalid <= 1'b0;
      end
    end
  end

  // Capture the read address on the AR handshake
  always_ff @(posedge clk) begin
    if (ar_hs) begin
      ar_addr <= s_axil_araddr;
    end
  end

  // The bank output only changes on a sample, so it stays stable through
  // R_RESP; it is masked to zero whenever no OKAY response is presented.
  assign s_axil_rdata = (s_axil_rvalid && s_axil_rresp == RESP_OKAY) ? bank_q : '0;

  z_core_ram_bank #(
    .MEM_WORDS  (MEM_WORDS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bank (
    .clk     (clk),
    .wr_en   (wr_commit & wr_hit),
    .wr_idx  (wr_idx),
    .wr_be   (w_strb),
    .wr_data (w_data),
    .rd_en   (rd_sample & rd_hit),
    .rd_idx  (rd_idx),
    .rd_data (bank_q)
  );

endmodule

// File: tb/tb_z_core_axil_ram.sv
// Self-checking bench for z_core_axil_ram: directed steps followed by a
// randomized write/read mix compared against a word-array reference model.
module tb_z_core_axil_ram;

  logic        clk, rstn, rstn3;
  logic [31:0] awaddr, wdata, araddr, araddr3;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready, arvalid3, rready3;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        awready3, wready3, bvalid3, arready3, rvalid3;
  logic [1:0]  bresp3, rresp3;
  logic [31:0] rdata3;

  int errors = 0;
  int checks = 0;
  logic [31:0] model [16];

  z_core_axil_ram #(.RD_WAIT(0)) dut (
    .clk(clk), .rstn(rstn),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready)
  );

  // Second instance with read wait states; it sees the same write traffic.
  z_core_axil_ram #(.RD_WAIT(3)) dut3 (
    .clk(clk), .rstn(rstn3),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready3),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready3),
    .s_axil_bresp(bresp3), .s_axil_bvalid(bvalid3), .s_axil_bready(bready),
    .s_axil_araddr(araddr3), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid3), .s_axil_arready(arready3),
    .s_axil_rdata(rdata3), .s_axil_rresp(rresp3), .s_axil_rvalid(rvalid3), .s_axil_rready(rready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic in_range(input logic [31:0] a);
    return a < 32'd4096;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // order: 0 = AW and W together, 1 = W first, 2 = AW first; gap in cycles.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int order, input int gap, input int hold,
                          input logic [1:0] exp_resp, input string tag);
    bit aw_done, w_done, hs_a, hs_w;
    int t, ta, tw, lat;
    aw_done = 0; w_done = 0; t = 0;
    tw = (order == 2) ? gap : 0;
    ta = (order == 1) ? gap : 0;
    bready = 1'b0;
    while (!(aw_done && w_done) && t < 50) begin
      if (!w_done && t >= tw) begin wvalid = 1'b1; wdata = d; wstrb = s; end
      if (!aw_done && t >= ta) begin awvalid = 1'b1; awaddr = a; end
      hs_w = wvalid & wready;
      hs_a = awvalid & awready;
      @(posedge clk); #1; t++;
      if (hs_w) begin w_done = 1; wvalid = 1'b0; end
      if (hs_a) begin aw_done = 1; awvalid = 1'b0; end
      if (w_done && !aw_done) begin
        chk({tag, "_wready_held"}, 32'(wready), 32'd0);
        chk({tag, "_awready_open"}, 32'(awready), 32'd1);
        chk({tag, "_bvalid_early"}, 32'(bvalid), 32'd0);
      end
      if (aw_done && !w_done) begin
        chk({tag, "_awready_held"}, 32'(awready), 32'd0);
        chk({tag, "_wready_open"}, 32'(wready), 32'd1);
      end
    end
    chk({tag, "_hs_timeout"}, 32'(aw_done && w_done), 32'd1);
    awvalid = 1'b0; wvalid = 1'b0;
    lat = 0;
    while (!bvalid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk({tag, "_b_latency"}, 32'(lat), 32'd2);
    chk({tag, "_bresp"}, 32'(bresp), 32'(exp_resp));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_bvalid_hold"}, 32'(bvalid), 32'd1);
      chk({tag, "_bresp_hold"}, 32'(bresp), 32'(exp_resp));
      chk({tag, "_aw_w_ready_hold"}, {30'd0, awready, wready}, 32'd0);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk({tag, "_bvalid_drop"}, 32'(bvalid), 32'd0);
    chk({tag, "_awready_back"}, 32'(awready), 32'd1);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r,
                         input int hold, input string tag);
    int n, lat;
    bit hs;
    araddr = a; arvalid = 1'b1; rready = 1'b0; n = 0;
    while (arvalid && n < 20) begin
      hs = arready;
      @(posedge clk); #1; n++;
      if (hs) arvalid = 1'b0;
    end
    chk({tag, "_ar_timeout"}, 32'(arvalid), 32'd0);
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk({tag, "_r_latency"}, 32'(lat), 32'd1);
    chk({tag, "_rdata"}, rdata, exp_d);
    chk({tag, "_rresp"}, 32'(rresp), 32'(exp_r));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_rvalid_hold"}, 32'(rvalid), 32'd1);
      chk({tag, "_rdata_hold"}, rdata, exp_d);
      chk({tag, "_rresp_hold"}, 32'(rresp), 32'(exp_r));
      chk({tag, "_arready_hold"}, 32'(arready), 32'd0);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    chk({tag, "_rvalid_drop"}, 32'(rvalid), 32'd0);
    chk({tag, "_arready_back"}, 32'(arready), 32'd1);
  endtask

  // Issue a read on the RD_WAIT=3 instance and wait for rvalid (no R handshake).
  task automatic ar3(input logic [31:0] a, output int lat);
    int n;
    bit hs;
    araddr3 = a; arvalid3 = 1'b1; n = 0;
    while (arvalid3 && n < 20) begin
      hs = arready3;
      @(posedge clk); #1; n++;
      if (hs) arvalid3 = 1'b0;
    end
    chk("ar3_timeout", 32'(arvalid3), 32'd0);
    arvalid3 = 1'b0;
    lat = 0;
    while (!rvalid3 && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask

  initial begin
    logic [31:0] a, d, ra, exp_d;
    logic [3:0]  s;
    logic [1:0]  exp_r;
    int          lat, widx, ridx;
    bit          oob, roob;

    rstn = 1'b0; rstn3 = 1'b0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0; araddr3 = '0;
    awprot = 3'd0; arprot = 3'd0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arvalid = 1'b0; rready = 1'b0; arvalid3 = 1'b0; rready3 = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_bresp", 32'(bresp), 32'd0);
    chk("rst_rresp", 32'(rresp), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_readies", {29'd0, awready, wready, arready}, 32'd7);
    rstn = 1'b1; rstn3 = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_readies", {29'd0, awready, wready, arready}, 32'd7);

    // Initialise words 0..15 with full-word writes
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      do_write(32'(i) * 4, d, 4'hF, 0, 0, 0, 2'b00, "init");
      model[i] = d;
    end

    // Full word store then read back, AW and W on the same edge
    do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, "sw_same_edge");
    model[4] = 32'hDEADBEEF;
    do_read(32'h10, 32'hDEADBEEF, 2'b00, 0, "lw_10");

    // W three cycles ahead of AW
    do_write(32'h18, 32'h0BADF00D, 4'hF, 1, 3, 0, 2'b00, "w_first");
    model[6] = 32'h0BADF00D;
    do_read(32'h18, model[6], 2'b00, 0, "lw_18");

    // Single-byte strobe merges into an existing word
    do_write(32'h20, 32'h11223344, 4'hF, 0, 0, 0, 2'b00, "sw_20");
    do_write(32'h20, 32'h00AA0000, 4'b0100, 2, 2, 0, 2'b00, "sb_20");
    model[8] = 32'h11AA3344;
    do_read(32'h20, 32'h11AA3344, 2'b00, 0, "lw_20_merge");

    // Zero strobe writes nothing but is still OKAY
    do_write(32'h24, 32'hFFFFFFFF, 4'b0000, 0, 0, 0, 2'b00, "strb0");
    do_read(32'h24, model[9], 2'b00, 0, "lw_24_strb0");

    // First address past the window: SLVERR, array untouched
    do_write(32'd4096, 32'hCAFEF00D, 4'hF, 0, 0, 0, 2'b10, "sw_oob");
    do_read(32'd0, model[0], 2'b00, 0, "lw_0_after_oob");
    do_read(32'd4096, 32'd0, 2'b10, 0, "lw_oob");
    do_read(32'hFFFF_FFFC, 32'd0, 2'b10, 0, "lw_top");

    // Response back-pressure for five cycles on both channels
    do_write(32'h28, 32'h5A5A1234, 4'hF, 0, 0, 5, 2'b00, "b_stall");
    model[10] = 32'h5A5A1234;
    do_read(32'h28, 32'h5A5A1234, 2'b00, 5, "r_stall");

    // Write commit and read sample on the same edge to the same word
    d = model[5];
    fork
      do_write(32'h14, 32'h600DCAFE, 4'hF, 0, 0, 0, 2'b00, "col_w");
      begin
        @(posedge clk); #1;
        do_read(32'h14, d, 2'b00, 0, "col_r_old");
      end
    join
    model[5] = 32'h600DCAFE;
    do_read(32'h14, 32'h600DCAFE, 2'b00, 0, "col_r_new");

    // Randomized writes and reads against the model
    for (int k = 0; k < 40; k++) begin
      oob  = ($urandom_range(0, 7) == 0);
      widx = $urandom_range(0, 15);
      a = oob ? (32'd4096 + 32'($urandom_range(0, 1023)) * 4)
              : (32'(widx) * 4 + 32'($urandom_range(0, 3)));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      do_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2),
               in_range(a) ? 2'b00 : 2'b10, "rnd_w");
      if (in_range(a)) model[a[5:2]] = merge(model[a[5:2]], d, s);
      roob = ($urandom_range(0, 7) == 0);
      ridx = $urandom_range(0, 15);
      ra = roob ? (32'h0001_0000 + 32'($urandom)) % 32'hFFFF_0000 + 32'd4096
                : (32'(ridx) * 4 + 32'($urandom_range(0, 3)));
      exp_d = in_range(ra) ? model[ra[5:2]] : 32'd0;
      exp_r = in_range(ra) ? 2'b00 : 2'b10;
      do_read(ra, exp_d, exp_r, $urandom_range(0, 2), "rnd_r");
    end

    // RD_WAIT=3 instance: reset in the middle of the wait
    araddr3 = 32'h10; arvalid3 = 1'b1;
    @(posedge clk); #1;
    arvalid3 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("w3_mid_wait_rvalid", 32'(rvalid3), 32'd0);
    rstn3 = 1'b0;
    #1;
    chk("w3_rst_rvalid", 32'(rvalid3), 32'd0);
    chk("w3_rst_arready", 32'(arready3), 32'd1);
    arvalid3 = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    arvalid3 = 1'b0;
    rstn3 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("w3_abandoned_rvalid", 32'(rvalid3), 32'd0);
    end
    chk("w3_arready_after_rst", 32'(arready3), 32'd1);
    ar3(32'h10, lat);
    chk("w3_latency", 32'(lat), 32'd4);
    chk("w3_rdata", rdata3, model[4]);
    chk("w3_rresp", 32'(rresp3), 32'd0);
    rready3 = 1'b1;
    @(posedge clk); #1;
    rready3 = 1'b0;
    chk("w3_rvalid_drop", 32'(rvalid3), 32'd0);

    // Reset while a response is being presented clears it without a clock edge
    ar3(32'h28, lat);
    chk("w3_resp_latency", 32'(lat), 32'd4);
    chk("w3_resp_pending", 32'(rvalid3), 32'd1);
    rstn3 = 1'b0;
    #1;
    chk("w3_async_rvalid", 32'(rvalid3), 32'd0);
    chk("w3_async_rdata", rdata3, 32'd0);
    @(posedge clk); #1;
    rstn3 = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
